// File: rtl/sd_seq_fsm.sv
// rtl/sd_seq_fsm.sv - SD bus sequencer: card init, CMD18/CMD25 group loop, CMD15 terminate
// Optional macro SD_SEQ_POLL_LIMIT_EN bounds the ACMD41 busy poll to POLL_MAX responses.
module sd_seq_fsm #(
  parameter int unsigned       ADDR_W   = 20,
  parameter int unsigned       ADDR_LSB = 12,
  parameter logic [ADDR_W-1:0] END_ADDR = {ADDR_W{1'b1}},
  parameter int unsigned       POLL_MAX = 1000
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
  input  logic              icmd_done,
  input  logic              icmd_err,
  input  logic [31:0]       iresp,
  input  logic              istop_data,
  input  logic              iread_done,
  input  logic              iwrite_done,
  input  logic              iotp_ready,
  output logic              osel_clk,
  output logic              ogen_otp,
  output logic              onew_otp,
  output logic              ostart_cmd,
  output logic [5:0]        oindex,
  output logic [31:0]       oarg,
  output logic              ostart_d,
  output logic              osuccess,
  output logic              ofail,
  output logic [5:0]        ofail_idx,
  output logic [ADDR_W-1:0] oaddr,
  output logic              obusy
);

  typedef enum logic [5:0] {
    S_IDLE   = 6'd0,  S_CMD2  = 6'd2,  S_CMD3  = 6'd3,  S_ACMD6 = 6'd6,
    S_CMD7   = 6'd7,  S_CMD9  = 6'd9,  S_CMD12 = 6'd12, S_CMD15 = 6'd15,
    S_CMD18  = 6'd18, S_READ  = 6'd19, S_WAIT  = 6'd20, S_WRITE = 6'd21,
    S_CMD25  = 6'd25, S_ACMD41 = 6'd41, S_CMD55 = 6'd55
  } state_t;

  state_t              r_state, w_next;
  logic                r_istart_q;
  logic [15:0]         r_rca;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_done;
  logic                r_sel_clk, r_start_cmd, r_start_d, r_gen_otp;
  logic                r_success, r_fail;
  logic [5:0]          r_fail_idx;
  logic [31:0]         w_arg;
  logic [31:0]         w_addr_ext;
  logic                w_start, w_next_is_cmd, w_change, w_acmd41_busy, w_poll_hit;
  logic                w_unused_ok;

  assign w_start    = istart & ~r_istart_q;
  assign w_change   = (w_next != r_state);
  assign w_addr_ext = 32'(r_addr);
  assign w_acmd41_busy = (r_state == S_ACMD41) && icmd_done && !icmd_err &&
                         (iresp[21:20] != 2'b00) && !iresp[31];

`ifdef SD_SEQ_POLL_LIMIT_EN
  logic [15:0] r_poll;
  logic [15:0] w_poll_inc;
  assign w_poll_inc  = r_poll + 16'd1;
  assign w_poll_hit  = (w_poll_inc == POLL_MAX[15:0]);
  assign w_unused_ok = &{1'b0, iresp[19:13], iresp[8:6], iresp[4:0]};

  always_ff @(posedge iclk or posedge irst) begin
    if (irst)                          r_poll <= 16'd0;
    else if (r_state == S_IDLE && w_start) r_poll <= 16'd0;
    else if (w_acmd41_busy)            r_poll <= w_poll_inc;
  end
`else
  assign w_poll_hit  = 1'b0;
  assign w_unused_ok = &{1'b0, iresp[19:13], iresp[8:6], iresp[4:0], (POLL_MAX != 0)};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_CMD55;
      S_READ:  if (istop_data || iwrite_done) w_next = S_CMD12;
      S_WRITE: if (istop_data) w_next = S_CMD12;
      S_WAIT: begin
        if (iwrite_done)                   w_next = r_done ? S_CMD15 : S_CMD18;
        else if (iread_done && iotp_ready) w_next = S_CMD25;
      end
      default: begin
        // command states: an error aborts even if the response arrives the same cycle
        if (icmd_err) begin
          w_next = S_IDLE;
        end else if (icmd_done) begin
          case (r_state)
            S_CMD55:  w_next = !iresp[5] ? S_IDLE : (r_sel_clk ? S_ACMD6 : S_ACMD41);
            S_ACMD41: begin
              if (iresp[21:20] == 2'b00) w_next = S_IDLE;
              else if (iresp[31])        w_next = S_CMD2;
              else                       w_next = w_poll_hit ? S_IDLE : S_CMD55;
            end
            S_CMD2:  w_next = S_CMD3;
            S_CMD3:  w_next = S_CMD9;
            S_CMD9:  w_next = S_CMD7;
            S_CMD7:  w_next = S_CMD55;
            S_ACMD6: w_next = (iresp[12:9] == 4'd4) ? S_CMD18 : S_IDLE;
            S_CMD18: w_next = iresp[31] ? S_CMD15 : S_READ;
            S_CMD12: w_next = S_WAIT;
            S_CMD25: w_next = S_WRITE;
            default: w_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

  assign w_next_is_cmd = (w_next != S_IDLE) && (w_next != S_READ) &&
                         (w_next != S_WAIT) && (w_next != S_WRITE);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state     <= S_IDLE;
      r_istart_q  <= 1'b0;
      r_rca       <= 16'd0;
      r_addr      <= '0;
      r_done      <= 1'b0;
      r_sel_clk   <= 1'b0;
      r_start_cmd <= 1'b0;
      r_start_d   <= 1'b0;
      r_gen_otp   <= 1'b0;
      r_success   <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_idx  <= 6'd0;
    end else begin
      r_state     <= w_next;
      r_istart_q  <= istart;
      r_start_cmd <= w_change && w_next_is_cmd;
      r_start_d   <= w_change && (w_next == S_CMD18 || w_next == S_WRITE);
      r_gen_otp   <= w_change && (w_next == S_READ);
      if (r_state == S_IDLE && w_start) begin
        r_success  <= 1'b0;
        r_fail     <= 1'b0;
        r_fail_idx <= 6'd0;
        r_addr     <= '0;
        r_done     <= 1'b0;
      end
      if (r_state == S_CMD3 && w_next == S_CMD9) r_rca <= iresp[31:16];
      if (w_change && w_next == S_CMD9) r_sel_clk <= 1'b1;
      if (w_change && w_next == S_IDLE) begin
        r_sel_clk <= 1'b0;
        if (r_state == S_CMD15) begin
          r_success <= 1'b1;
        end else begin
          r_fail     <= 1'b1;
          r_fail_idx <= r_state;
        end
      end
      if (r_state == S_WRITE && w_change) begin
        if (r_addr == END_ADDR) begin
          r_addr <= '0;
          r_done <= 1'b1;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_arg = 32'hFFFF_FFFF;
    case (r_state)
      S_CMD55:                   w_arg[31:16] = r_sel_clk ? r_rca : 16'h0000;
      S_ACMD41:                  w_arg = 32'h8030_0000;
      S_CMD9, S_CMD7, S_CMD15:   w_arg[31:16] = r_rca;
      S_ACMD6:                   w_arg[0] = 1'b0;
      S_CMD18, S_CMD25:          w_arg = w_addr_ext << ADDR_LSB;
      default:                   w_arg = 32'hFFFF_FFFF;
    endcase
  end

  assign oarg       = w_arg;
  assign oindex     = r_state;
  assign onew_otp   = (r_state == S_IDLE);
  assign obusy      = (r_state != S_IDLE);
  assign osel_clk   = r_sel_clk;
  assign ostart_cmd = r_start_cmd;
  assign ostart_d   = r_start_d;
  assign ogen_otp   = r_gen_otp;
  assign osuccess   = r_success;
  assign ofail      = r_fail;
  assign ofail_idx  = r_fail_idx;
  assign oaddr      = r_addr;

endmodule

// File: tb/tb_sd_seq_fsm.sv
// tb/tb_sd_seq_fsm.sv - directed self-checking bench for sd_seq_fsm (ADDR_W=4, END_ADDR=1, POLL_MAX=3)
module tb_sd_seq_fsm;
  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        istart = 1'b0, icmd_done = 1'b0, icmd_err = 1'b0;
  logic [31:0] iresp = 32'd0;
  logic        istop_data = 1'b0, iread_done = 1'b0, iwrite_done = 1'b0, iotp_ready = 1'b0;
  logic        osel_clk, ogen_otp, onew_otp, ostart_cmd, ostart_d, osuccess, ofail, obusy;
  logic [5:0]  oindex, ofail_idx;
  logic [31:0] oarg;
  logic [3:0]  oaddr;
  int          total = 0;
  int          bad = 0;

  sd_seq_fsm #(.ADDR_W(4), .ADDR_LSB(12), .END_ADDR(4'd1), .POLL_MAX(3)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .icmd_done(icmd_done), .icmd_err(icmd_err),
    .iresp(iresp), .istop_data(istop_data), .iread_done(iread_done), .iwrite_done(iwrite_done),
    .iotp_ready(iotp_ready), .osel_clk(osel_clk), .ogen_otp(ogen_otp), .onew_otp(onew_otp),
    .ostart_cmd(ostart_cmd), .oindex(oindex), .oarg(oarg), .ostart_d(ostart_d),
    .osuccess(osuccess), .ofail(ofail), .ofail_idx(ofail_idx), .oaddr(oaddr), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iclk); #1;
  endtask

  task automatic cmd_ok(input logic [31:0] r);
    iresp = r; icmd_done = 1'b1; step(); icmd_done = 1'b0; iresp = 32'd0;
  endtask

  task automatic pulse_stop();
    istop_data = 1'b1; step(); istop_data = 1'b0;
  endtask

  task automatic restart();
    istart = 1'b0; step(); istart = 1'b1; step();
  endtask

  // CMD55 (osel=0) through to CMD18 with rca 0x1234
  task automatic do_init();
    cmd_ok(32'h0000_0020);
    cmd_ok(32'h8030_0000);
    cmd_ok(32'h0);
    cmd_ok(32'h1234_0000);
    cmd_ok(32'h0);
    cmd_ok(32'h0);
    cmd_ok(32'h0000_0020);
    cmd_ok(32'h0000_0800);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_idx", oindex, 0);
    chk("rst_arg", oarg, 32'hFFFF_FFFF);
    chk("rst_new", onew_otp, 1);
    chk("rst_flags", {obusy, osuccess, ofail, osel_clk, ostart_cmd, ostart_d, ogen_otp}, 0);
    irst = 1'b0; step();

    // full run
    istart = 1'b1; step();
    chk("start_idx", oindex, 55);
    chk("start_pulse", ostart_cmd, 1);
    chk("cmd55_arg0", oarg, 32'h0000_FFFF);
    step();
    chk("pulse_one", ostart_cmd, 0);
    cmd_ok(32'h0000_0020);
    chk("acmd41_idx", oindex, 41);
    chk("acmd41_arg", oarg, 32'h8030_0000);
    cmd_ok(32'h8030_0000); chk("cmd2", oindex, 2);
    cmd_ok(32'h0);         chk("cmd3", oindex, 3);
    cmd_ok(32'h1234_0000);
    chk("cmd9", oindex, 9);
    chk("cmd9_sel", osel_clk, 1);
    chk("cmd9_arg", oarg, 32'h1234_FFFF);
    cmd_ok(32'h0); chk("cmd7", oindex, 7);
    cmd_ok(32'h0);
    chk("cmd55b", oindex, 55);
    chk("cmd55_arg1", oarg, 32'h1234_FFFF);
    cmd_ok(32'h0000_0020);
    chk("acmd6", oindex, 6);
    chk("acmd6_arg", oarg, 32'hFFFF_FFFE);
    cmd_ok(32'h0000_0800);
    chk("cmd18", oindex, 18);
    chk("cmd18_arg0", oarg, 32'h0);
    chk("cmd18_d", ostart_d, 1);
    cmd_ok(32'h0);
    chk("read", oindex, 19);
    chk("read_otp", ogen_otp, 1);
    pulse_stop(); chk("cmd12", oindex, 12);
    cmd_ok(32'h0); chk("wait", oindex, 20);
    iread_done = 1'b1; iotp_ready = 1'b1; step(); iread_done = 1'b0; iotp_ready = 1'b0;
    chk("cmd25", oindex, 25);
    chk("cmd25_arg", oarg, 32'h0);
    cmd_ok(32'h0);
    chk("write", oindex, 21);
    chk("write_d", ostart_d, 1);
    pulse_stop();
    chk("addr1", oaddr, 1);
    cmd_ok(32'h0);
    iwrite_done = 1'b1; iread_done = 1'b1; iotp_ready = 1'b1; step();
    iwrite_done = 1'b0; iread_done = 1'b0; iotp_ready = 1'b0;
    chk("prio_idx", oindex, 18);
    chk("prio_d", ostart_d, 1);
    chk("cmd18_arg1", oarg, 32'h0000_1000);
    step();
    chk("prio_d_off", ostart_d, 0);
    cmd_ok(32'h0); pulse_stop(); cmd_ok(32'h0);
    iread_done = 1'b1; iotp_ready = 1'b1; step(); iread_done = 1'b0; iotp_ready = 1'b0;
    cmd_ok(32'h0); pulse_stop();
    chk("addr_wrap", oaddr, 0);
    cmd_ok(32'h0);
    iwrite_done = 1'b1; step(); iwrite_done = 1'b0;
    chk("cmd15", oindex, 15);
    chk("cmd15_arg", oarg, 32'h1234_FFFF);
    cmd_ok(32'h0);
    chk("end_idx", oindex, 0);
    chk("end_ok", {osuccess, ofail}, 2'b10);
    chk("end_sel", osel_clk, 0);
    repeat (3) step();
    chk("held_no_restart", oindex, 0);
    restart();
    chk("restart_idx", oindex, 55);
    chk("restart_succ", osuccess, 0);

    // bounded ACMD41 poll
    for (int i = 0; i < 3; i++) begin
      cmd_ok(32'h0000_0020);
      cmd_ok(32'h0030_0000);
    end
`ifdef SD_SEQ_POLL_LIMIT_EN
    chk("poll_idx", oindex, 0);
    chk("poll_fail", {ofail, ofail_idx}, {1'b1, 6'd41});
`else
    chk("poll_loop", oindex, 55);
    icmd_err = 1'b1; step(); icmd_err = 1'b0;
    chk("poll_abort", {ofail, ofail_idx}, {1'b1, 6'd55});
`endif

    // error in CMD9, error wins over done
    restart();
    chk("err_clear", ofail, 0);
    cmd_ok(32'h0000_0020); cmd_ok(32'h8030_0000); cmd_ok(32'h0); cmd_ok(32'h1234_0000);
    icmd_err = 1'b1; icmd_done = 1'b1; step(); icmd_err = 1'b0; icmd_done = 1'b0;
    chk("err_idx", oindex, 0);
    chk("err_fail", {ofail, ofail_idx, osel_clk}, {1'b1, 6'd9, 1'b0});

    // CMD18 out of range
    restart();
    do_init();
    chk("oor_cmd18", oindex, 18);
    cmd_ok(32'h8000_0000);
    chk("oor_cmd15", oindex, 15);
    cmd_ok(32'h0);
    chk("oor_succ", {osuccess, ofail}, 2'b10);

    // asynchronous reset mid-run
    restart();
    do_init();
    #2 irst = 1'b1; #1;
    chk("arst_idx", oindex, 0);
    chk("arst_flags", {osuccess, ofail, osel_clk}, 0);
    step(); irst = 1'b0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
